sdr_block_streamer: RTL and testbench

//  Read-side sequencer between the SDRAM block-read bridge (sdr_readstart/readend/readdata)
//  and the ray-tracing core. Splits a word transfer into BLOCK_W-bit bursts, issues each

---
 rtl/sdr_block_streamer.sv | 160 ++++++++++++++++
 tb/tb_sdr_block_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_block_streamer.sv
// SDRAM block-read sequencer: splits a word transfer into bridge bursts
// and streams each returned block out as words over valid/ready.
module sdr_block_streamer #(
  parameter int BLOCK_W     = 2048,
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NELEMS_W    = 30,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                sdr_clk,
  input  logic                sdr_reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [NELEMS_W-1:0] total_words,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                sdr_readstart,
  output logic [ADDR_W-1:0]   sdr_baseaddr,
  output logic [NELEMS_W-1:0] sdr_nelems,
  input  logic                sdr_readend,
  input  logic [BLOCK_W-1:0]  sdr_readdata,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [WORD_W-1:0]   word_data,
  output logic                word_last
);

  localparam int WPB = BLOCK_W / WORD_W;
  localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic [NELEMS_W-1:0]         r_rem;
  logic [IW-1:0]               r_idx;
  logic [31:0]                 r_tcnt;
  logic [WPB-1:0][WORD_W-1:0]  r_block;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_rs;
  logic [ADDR_W-1:0]           r_addr;
  logic [NELEMS_W-1:0]         r_nel;
  logic                        r_valid;

  logic                        w_hs;
  logic                        w_burst_end;
  logic                        w_to_hit;
  logic [NELEMS_W-1:0]         w_rem_dec;

  function automatic logic [NELEMS_W-1:0] f_nel(
    input logic [NELEMS_W-1:0] x
  );
    return (x > NELEMS_W'(WPB)) ? NELEMS_W'(WPB) : x;
  endfunction

  assign w_hs        = r_valid && word_ready;
  assign w_burst_end = NELEMS_W'(r_idx) == (r_nel - NELEMS_W'(1));
  assign w_rem_dec   = r_rem - NELEMS_W'(1);
  assign w_to_hit    = (TIMEOUT_CYC != 0) &&
                       (r_tcnt == 32'(TIMEOUT_CYC - 1));

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign sdr_readstart = r_rs;
  assign sdr_baseaddr  = r_addr;
  assign sdr_nelems    = r_nel;
  assign word_valid    = r_valid;
  assign word_data     = r_valid ? r_block[r_idx] : '0;
  assign word_last     = r_valid && (r_rem == NELEMS_W'(1));

  // Transfer sequencer: burst requests, block capture and word streaming.
  always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
    if (!sdr_reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
      r_tcnt  <= '0;
      r_block <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rs    <= 1'b0;
      r_addr  <= '0;
      r_nel   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rs   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= base_addr;
            r_rem  <= total_words;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            if (total_words == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_nel   <= f_nel(total_words);
              r_rs    <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (sdr_readend) begin
            r_block <= sdr_readdata;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_state <= S_STREAM;
          end else if (w_to_hit) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            r_rem <= w_rem_dec;
            r_idx <= r_idx + IW'(1);
            if (w_burst_end) begin
              r_valid <= 1'b0;
              if (w_rem_dec == '0) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_addr  <= r_addr + ADDR_W'(BLOCK_W / 8);
                r_nel   <= f_nel(w_rem_dec);
                r_rs    <= 1'b1;
                r_state <= S_REQ;
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_block_streamer.sv
// Bench for sdr_block_streamer: cycle-driven bridge and consumer
// checked against an address-to-word memory model.
module tb_sdr_block_streamer;

  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [29:0]   total_words = '0;
  logic          busy, done, err;
  logic          sdr_readstart;
  logic [31:0]   sdr_baseaddr;
  logic [29:0]   sdr_nelems;
  logic          sdr_readend = 1'b0;
  logic [2047:0] sdr_readdata = '0;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [31:0]   word_data;
  logic          word_last;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] seed;

  always #5 clk = ~clk;

  sdr_block_streamer #(
    .BLOCK_W(2048), .WORD_W(32), .ADDR_W(32),
    .NELEMS_W(30), .TIMEOUT_CYC(TO)
  ) dut (
    .sdr_clk(clk),
    .sdr_reset_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .total_words(total_words),
    .busy(busy),
    .done(done),
    .err(err),
    .sdr_readstart(sdr_readstart),
    .sdr_baseaddr(sdr_baseaddr),
    .sdr_nelems(sdr_nelems),
    .sdr_readend(sdr_readend),
    .sdr_readdata(sdr_readdata),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data(word_data),
    .word_last(word_last)
  );

  // Memory contents as seen through the bridge: one word per 4 bytes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [2047:0] mk_block(
    input logic [31:0] addr, input int nel
  );
    logic [2047:0] b;
    for (int i = 0; i < 64; i++)
      b[i*32 +: 32] = (i < nel) ? mem_word(addr + 32'(4*i)) : $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: bridge answers after lat cycles (if on),
  // consumer ready is constant 1 or random.
  task automatic run_xfer(
    input string       nm,
    input logic [31:0] base,
    input int          total,
    input int          lat,
    input bit          rnd_ready,
    input bit          bridge_on
  );
    int n, nreq, cd, exp_req, exp_n, exp_nel;
    bit fin, stalled;
    logic [31:0] sdata, exp_addr;
    logic [2047:0] blk;
    n = 0; nreq = 0; cd = -1; fin = 0; stalled = 0;
    blk = '0;
    exp_req = !bridge_on ? 1 : (total + 63) / 64;
    exp_n = bridge_on ? total : 0;
    if (total == 0) exp_req = 0;
    base_addr = base;
    total_words = 30'(total);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
      sdr_readend = 1'b0;
      if (cyc == 1) begin
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s start_flags err=%b busy=%b want 0/1",
                   nm, err, busy);
        end
      end
      if (sdr_readstart) begin
        exp_addr = base + 32'(256 * nreq);
        exp_nel = (total - 64*nreq > 64) ? 64 : total - 64*nreq;
        n_checks++;
        if (sdr_baseaddr !== exp_addr ||
            sdr_nelems !== 30'(exp_nel)) begin
          n_fail++;
          $display("FAIL %s req%0d addr=%h nel=%0d want %h/%0d",
                   nm, nreq, sdr_baseaddr, sdr_nelems,
                   exp_addr, exp_nel);
        end
        blk = mk_block(exp_addr, exp_nel);
        if (bridge_on) cd = lat;
        nreq++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sdr_readend = 1'b1;
          sdr_readdata = blk;
          cd = -1;
        end
      end
      if (stalled) begin
        n_checks++;
        if (word_valid !== 1'b1 || word_data !== sdata) begin
          n_fail++;
          $display("FAIL %s stall v=%b d=%h want 1/%h",
                   nm, word_valid, word_data, sdata);
        end
        stalled = 0;
      end
      word_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
      if (word_valid) begin
        if (word_ready) begin
          n_checks++;
          if (n >= total ||
              word_data !== mem_word(base + 32'(4*n)) ||
              word_last !== (n == total - 1)) begin
            n_fail++;
            $display("FAIL %s word%0d d=%h l=%b want %h/%b",
                     nm, n, word_data, word_last,
                     mem_word(base + 32'(4*n)), n == total - 1);
          end
          n++;
        end else begin
          stalled = 1;
          sdata = word_data;
        end
      end
      if (done) begin
        fin = 1;
        n_checks++;
        if (err !== !bridge_on) begin
          n_fail++;
          $display("FAIL %s err_at_done err=%b want %b",
                   nm, err, !bridge_on);
        end
        if (total == 0 || !bridge_on) begin
          n_checks++;
          if (cyc != (total == 0 ? 1 : TO + 2)) begin
            n_fail++;
            $display("FAIL %s done_cycle got=%0d want %0d",
                     nm, cyc, total == 0 ? 1 : TO + 2);
          end
        end
      end
      tick();
    end
    sdr_readend = 1'b0;
    word_ready = 1'b0;
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s done_timeout got=0 want 1", nm);
    end
    n_checks++;
    if (n != exp_n || nreq != exp_req) begin
      n_fail++;
      $display("FAIL %s counts words=%0d reqs=%0d want %0d/%0d",
               nm, n, nreq, exp_n, exp_req);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done busy=%b done=%b want 0/0",
               nm, busy, done);
    end
  endtask

  task automatic chk_idle_outs(input string nm);
    n_checks++;
    if ({busy, done, err, sdr_readstart, word_valid, word_last}
          !== 6'b0 ||
        sdr_baseaddr !== 32'h0 || sdr_nelems !== 30'h0 ||
        word_data !== 32'h0) begin
      n_fail++;
      $display("FAIL %s outs b%b d%b e%b rs%b v%b l%b a=%h n=%0d w=%h want 0",
               nm, busy, done, err, sdr_readstart, word_valid,
               word_last, sdr_baseaddr, sdr_nelems, word_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    chk_idle_outs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_words();
    seed = $urandom;
    run_xfer("zero", 32'h1000, 0, 5, 0, 1);
  endtask

  task automatic test_single_burst();
    seed = $urandom;
    run_xfer("single", 32'h1000, 64, 10, 0, 1);
  endtask

  task automatic test_multi_burst();
    seed = $urandom;
    run_xfer("multi", 32'h1000, 150, 7, 0, 1);
  endtask

  task automatic test_random_ready();
    for (int k = 0; k < 6; k++) begin
      seed = $urandom;
      run_xfer($sformatf("rnd%0d", k),
               (k == 0) ? 32'hFFFFFF00 : ($urandom & 32'hFFFFFFFC),
               $urandom_range(1, 200), $urandom_range(1, 20), 1, 1);
    end
  endtask

  task automatic test_timeout();
    seed = $urandom;
    run_xfer("timeout", 32'h4000, 10, 1, 1, 0);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout sticky_err got=%b want 1", err);
    end
    seed = $urandom;
    run_xfer("err_clear", 32'h5000, 3, 2, 0, 1);
  endtask

  task automatic test_back_to_back();
    seed = $urandom;
    run_xfer("b2b_a", 32'h8000, 70, 1, 0, 1);
    run_xfer("b2b_b", 32'h9000, 65, 1, 1, 1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    seed = $urandom;
    base_addr = 32'h2000;
    total_words = 30'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (sdr_readstart) seen = 1;
      else tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid readstart got=0 want 1");
    end
    tick();
    sdr_readend = 1'b1;
    sdr_readdata = mk_block(32'h2000, 64);
    tick();
    sdr_readend = 1'b0;
    word_ready = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (word_valid !== 1'b1 ||
        word_data !== mem_word(32'h2000 + 32'd20)) begin
      n_fail++;
      $display("FAIL rstmid stream v=%b d=%h want 1/%h",
               word_valid, word_data, mem_word(32'h2014));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rst_async");
    start = 1'b1;
    sdr_readend = 1'b1;
    tick();
    chk_idle_outs("rst_glitch");
    start = 1'b0;
    sdr_readend = 1'b0;
    rst_n = 1'b1;
    tick();
    sdr_readend = 1'b1;
    tick();
    sdr_readend = 1'b0;
    word_ready = 1'b0;
    repeat (3) begin
      chk_idle_outs("rst_late_readend");
      tick();
    end
    seed = $urandom;
    run_xfer("after_rst", 32'h3000, 90, 4, 1, 1);
  endtask

  initial begin
    test_reset();
    test_zero_words();
    test_single_burst();
    test_multi_burst();
    test_random_ready();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
